// File: rtl/cam_access_ctrl.sv
// Arbitrates and sequences lookup/write traffic onto the single password-CAM port.
// Optional statistics counters are built when CAM_CTRL_STATS_EN is defined.
module cam_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LOOKUP_LAT = 1,
  parameter int unsigned WR_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_lu_valid,
  output logic                  o_lu_ready,
  input  logic [DATA_WIDTH-1:0] i_lu_key,
  output logic                  o_lu_rsp_valid,
  output logic                  o_lu_rsp_hit,
  output logic [ADDR_WIDTH-1:0] o_lu_rsp_addr,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_key,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  output logic                  o_wr_done,
  output logic                  o_wr_err,
  output logic                  o_cam_write_enable,
  output logic [DATA_WIDTH-1:0] o_cam_din,
  output logic [DATA_WIDTH-1:0] o_cam_cmp_din,
  output logic [ADDR_WIDTH-1:0] o_cam_write_addr,
  input  logic                  i_cam_busy,
  input  logic                  i_cam_match,
  input  logic [ADDR_WIDTH-1:0] i_cam_match_addr
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]           o_stat_hits,
  output logic [15:0]           o_stat_misses,
  output logic [15:0]           o_stat_wr_timeouts
`endif
);

  localparam int unsigned TO_W = $clog2(WR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WR_ISSUE,
    S_WR_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_lat_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_last_wr;
  logic                  r_rsp_valid;
  logic                  r_rsp_hit;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic                  r_wr_done;
  logic                  r_wr_err;
  logic                  r_cam_we;
  logic [DATA_WIDTH-1:0] r_cam_din;
  logic [DATA_WIDTH-1:0] r_cam_cmp_din;
  logic [ADDR_WIDTH-1:0] r_cam_waddr;

  logic w_idle;
  logic w_lu_accept;
  logic w_wr_accept;
  logic w_lu_fin;
  logic w_wr_ok;
  logic w_wr_to;

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Readies are gated by reset so nothing is granted while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_idle      = 1'b0;
    w_lu_accept = 1'b0;
    w_wr_accept = 1'b0;
    w_lu_fin    = 1'b0;
    w_wr_ok     = 1'b0;
    w_wr_to     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle      = i_rst & ~i_cam_busy;
        w_lu_accept = w_idle & i_lu_valid & (~i_wr_valid | r_last_wr);
        w_wr_accept = w_idle & i_wr_valid & (~i_lu_valid | ~r_last_wr);
        if (w_lu_accept)      w_state_nxt = S_LOOKUP;
        else if (w_wr_accept) w_state_nxt = S_WR_ISSUE;
      end
      S_LOOKUP: begin
        if (r_lat_cnt == 3'd0) begin
          w_lu_fin    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_ISSUE: w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        // A zero counter marks the first wait cycle, where busy may not have risen yet.
        if (r_to_cnt != '0) begin
          if (!i_cam_busy) begin
            w_wr_ok     = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_to_cnt == TO_W'(WR_TIMEOUT)) begin
            w_wr_to     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_lat_cnt     <= '0;
      r_to_cnt      <= '0;
      r_last_wr     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_addr    <= '0;
      r_wr_done     <= 1'b0;
      r_wr_err      <= 1'b0;
      r_cam_we      <= 1'b0;
      r_cam_din     <= '0;
      r_cam_cmp_din <= '0;
      r_cam_waddr   <= '0;
    end else begin
      r_rsp_valid <= w_lu_fin;
      r_rsp_hit   <= w_lu_fin & i_cam_match;
      r_rsp_addr  <= (w_lu_fin & i_cam_match) ? i_cam_match_addr : '0;
      r_wr_done   <= w_wr_ok | w_wr_to;
      r_wr_err    <= w_wr_to;
      r_cam_we    <= (r_state == S_WR_ISSUE);

      if (w_lu_accept) begin
        r_cam_din <= i_lu_key;
        r_lat_cnt <= 3'(LOOKUP_LAT);
        r_last_wr <= 1'b0;
      end else if ((r_state == S_LOOKUP) && (r_lat_cnt != 3'd0)) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
      end

      if (w_wr_accept) begin
        r_cam_cmp_din <= i_wr_key;
        r_cam_waddr   <= i_wr_addr;
        r_last_wr     <= 1'b1;
      end

      if (r_state == S_WR_ISSUE) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_WR_WAIT) && (r_to_cnt != TO_W'(WR_TIMEOUT))) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign o_lu_ready         = w_lu_accept;
  assign o_wr_ready         = w_wr_accept;
  assign o_lu_rsp_valid     = r_rsp_valid;
  assign o_lu_rsp_hit       = r_rsp_hit;
  assign o_lu_rsp_addr      = r_rsp_addr;
  assign o_wr_done          = r_wr_done;
  assign o_wr_err           = r_wr_err;
  assign o_cam_write_enable = r_cam_we;
  assign o_cam_din          = r_cam_din;
  assign o_cam_cmp_din      = r_cam_cmp_din;
  assign o_cam_write_addr   = r_cam_waddr;

`ifdef CAM_CTRL_STATS_EN
  logic [15:0] r_stat_hits;
  logic [15:0] r_stat_misses;
  logic [15:0] r_stat_to;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_to     <= '0;
    end else begin
      if (w_lu_fin && i_cam_match && (r_stat_hits != '1))    r_stat_hits   <= r_stat_hits + 16'd1;
      if (w_lu_fin && !i_cam_match && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 16'd1;
      if (w_wr_to && (r_stat_to != '1))                      r_stat_to     <= r_stat_to + 16'd1;
    end
  end

  assign o_stat_hits        = r_stat_hits;
  assign o_stat_misses      = r_stat_misses;
  assign o_stat_wr_timeouts = r_stat_to;
`endif

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Directed bench for cam_access_ctrl: per-cycle vector table plus timeout and mid-op reset sequences.
module tb_cam_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, lu_valid, wr_valid, cam_busy, cam_match;
  logic [63:0] lu_key, wr_key;
  logic [4:0]  wr_addr, cam_match_addr;
  logic        lu_ready, lu_rsp_valid, lu_rsp_hit, wr_ready, wr_done, wr_err, cam_we;
  logic [4:0]  lu_rsp_addr, cam_waddr;
  logic [63:0] cam_din, cam_cmp_din;
`ifdef CAM_CTRL_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_to;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cam_access_ctrl #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(5),
    .LOOKUP_LAT(1),
    .WR_TIMEOUT(8)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_lu_valid        (lu_valid),
    .o_lu_ready        (lu_ready),
    .i_lu_key          (lu_key),
    .o_lu_rsp_valid    (lu_rsp_valid),
    .o_lu_rsp_hit      (lu_rsp_hit),
    .o_lu_rsp_addr     (lu_rsp_addr),
    .i_wr_valid        (wr_valid),
    .o_wr_ready        (wr_ready),
    .i_wr_key          (wr_key),
    .i_wr_addr         (wr_addr),
    .o_wr_done         (wr_done),
    .o_wr_err          (wr_err),
    .o_cam_write_enable(cam_we),
    .o_cam_din         (cam_din),
    .o_cam_cmp_din     (cam_cmp_din),
    .o_cam_write_addr  (cam_waddr),
    .i_cam_busy        (cam_busy),
    .i_cam_match       (cam_match),
    .i_cam_match_addr  (cam_match_addr)
`ifdef CAM_CTRL_STATS_EN
    ,
    .o_stat_hits       (stat_hits),
    .o_stat_misses     (stat_misses),
    .o_stat_wr_timeouts(stat_to)
`endif
  );

  typedef struct {
    logic       rst, luv, wrv, busy, match;
    logic [4:0] maddr, waddr;
    logic       lur, wrr, rv, hit;
    logic [4:0] raddr;
    logic       done, err, we;
    logic [4:0] ewa;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rs, lv, wv, bz, mt, input logic [4:0] ma, wa,
                              input logic er_lu, er_wr, erv, ehit, input logic [4:0] era,
                              input logic edone, eerr, ewe, input logic [4:0] ewa);
    vec_t v;
    v.rst = rs;  v.luv = lv; v.wrv = wv; v.busy = bz; v.match = mt; v.maddr = ma; v.waddr = wa;
    v.lur = er_lu; v.wrr = er_wr; v.rv = erv; v.hit = ehit; v.raddr = era;
    v.done = edone; v.err = eerr; v.we = ewe; v.ewa = ewa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] act_b, exp_b;
    int          k, done_k, we_cnt;
    logic        lu_leak, err_at_done;

    rst = 1'b0; lu_valid = 1'b1; wr_valid = 1'b1; cam_busy = 1'b0; cam_match = 1'b0;
    cam_match_addr = '0; wr_addr = '0;
    lu_key = 64'hDEAD_BEEF; wr_key = 64'h0123_4567_89AB_CDEF;

    //                rst luv wrv bsy mt maddr waddr | lur wrr rv hit raddr done err we ewa
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd3, 0, 1, 0, 0, 5'd0,  0, 0, 0, 5'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'd0,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 1, 5'd3));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'd0,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'd0,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 1, 0, 5'd0,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd3, 1, 0, 0, 0, 5'd0,  1, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 0, 1, 5'd5,  5'd3, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd7, 0, 1, 1, 1, 5'd5,  0, 0, 0, 5'd3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 1, 5'd7));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0,  5'd7, 1, 0, 0, 0, 5'd0,  1, 0, 0, 5'd7));
    vecs.push_back(mk(1, 1, 0, 0, 0, 5'd0,  5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 1, 0, 0, 0, 5'd9,  5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 1, 0, 0, 0, 5'd0,  5'd7, 1, 0, 1, 0, 5'd0,  0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd0,  5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5'd31, 5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 0, 1, 1, 0, 5'd0,  5'd7, 0, 0, 1, 1, 5'd31, 0, 0, 0, 5'd7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd0,  5'd7, 0, 0, 0, 0, 5'd0,  0, 0, 0, 5'd7));

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; lu_valid = vecs[i].luv; wr_valid = vecs[i].wrv;
      cam_busy = vecs[i].busy; cam_match = vecs[i].match;
      cam_match_addr = vecs[i].maddr; wr_addr = vecs[i].waddr;
      @(negedge clk);
      act_b = {lu_ready, wr_ready, lu_rsp_valid, lu_rsp_hit, lu_rsp_addr,
               wr_done, wr_err, cam_we, cam_waddr};
      exp_b = {vecs[i].lur, vecs[i].wrr, vecs[i].rv, vecs[i].hit, vecs[i].raddr,
               vecs[i].done, vecs[i].err, vecs[i].we, vecs[i].ewa};
      n_vec++;
      if (act_b !== exp_b) begin
        n_bad++;
        $display("FAIL vec%0d {lur,wrr,rv,hit,raddr,done,err,we,waddr}: got %b expected %b",
                 i, act_b, exp_b);
      end
    end
    chk("cam_din_held", cam_din, 64'hDEAD_BEEF);
    chk("cam_cmp_din_held", cam_cmp_din, 64'h0123_4567_89AB_CDEF);
`ifdef CAM_CTRL_STATS_EN
    chk("stat_hits", {48'd0, stat_hits}, 64'd2);
    chk("stat_misses", {48'd0, stat_misses}, 64'd1);
    chk("stat_to_zero", {48'd0, stat_to}, 64'd0);
`endif

    // Write timeout with busy stuck high; lookups must stay blocked throughout.
    @(posedge clk); #1;
    wr_valid = 1'b1; lu_valid = 1'b0; cam_busy = 1'b0; wr_addr = 5'd12;
    wr_key = 64'hFEED_0000_0000_0012;
    @(negedge clk);
    chk("to_wr_ready", {63'd0, wr_ready}, 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0; lu_valid = 1'b1; cam_busy = 1'b1;
    done_k = 0; we_cnt = 0; lu_leak = 1'b0; err_at_done = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lu_ready) lu_leak = 1'b1;
      if (cam_we) begin
        we_cnt++;
        chk("to_strobe_addr", {59'd0, cam_waddr}, 64'd12);
      end
      if (wr_done) begin
        done_k = k;
        err_at_done = wr_err;
        break;
      end
    end
    chk("to_done_cycle", 64'(done_k), 64'd11);
    chk("to_err", {63'd0, err_at_done}, 64'd1);
    chk("to_we_pulses", 64'(we_cnt), 64'd1);
    chk("to_lu_blocked", {63'd0, lu_leak}, 64'd0);
    chk("to_cmp_din", cam_cmp_din, 64'hFEED_0000_0000_0012);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("to_lu_blocked_idle", {63'd0, lu_ready}, 64'd0);
    end
    @(posedge clk); #1;
    cam_busy = 1'b0;
    @(negedge clk);
    chk("to_idle_lu_ready", {63'd0, lu_ready}, 64'd1);
    lu_valid = 1'b0;
`ifdef CAM_CTRL_STATS_EN
    chk("stat_to_one", {48'd0, stat_to}, 64'd1);
`endif

    // Reset during WR_WAIT abandons the write silently.
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 5'd20;
    @(negedge clk);
    chk("mr_wr_ready", {63'd0, wr_ready}, 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0; cam_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    chk("mr_we_in_reset", {63'd0, cam_we}, 64'd0);
    chk("mr_waddr_in_reset", {59'd0, cam_waddr}, 64'd0);
    rst = 1'b1; cam_busy = 1'b0;
    lu_leak = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (wr_done || cam_we) lu_leak = 1'b1;
    end
    chk("mr_no_done", {63'd0, lu_leak}, 64'd0);
    lu_valid = 1'b1; wr_valid = 1'b1;
    #1;
    chk("mr_tie_to_write", {62'd0, lu_ready, wr_ready}, 64'd1);
    lu_valid = 1'b0; wr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
